// File: rtl/fetch_dreg.sv
// fetch_dreg: Y86-64 fetch stage merged with the D pipeline register.
// Holds a byte-addressed instruction memory and F_predPC, selects the fetch PC,
// parses one instruction per cycle and registers it into D under stall/bubble control.
// Optional feature macro: FETCH_CNT_EN (enables the fetch_count counter; tied to 0 otherwise).
module fetch_dreg #(
    parameter int unsigned IMEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC  = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_we,
    input  logic [63:0] imem_addr,
    input  logic [7:0]  imem_wdata,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic [31:0] fetch_count
);

    localparam int unsigned AW = (IMEM_SIZE > 1) ? $clog2(IMEM_SIZE) : 1;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd2;
    localparam logic [2:0] SINS = 3'd3;
    localparam logic [2:0] SHLT = 3'd4;

    localparam logic [3:0] I_HALT = 4'd0;
    localparam logic [3:0] I_NOP  = 4'd1;
    localparam logic [3:0] I_JXX  = 4'd7;
    localparam logic [3:0] I_CALL = 4'd8;
    localparam logic [3:0] I_RET  = 4'd9;
    localparam logic [3:0] RNONE  = 4'hF;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [7:0]  r_imem [IMEM_SIZE];
    logic [63:0] r_pred_pc;
    logic [0:0]  r_state;

    logic [2:0]  r_d_stat;
    logic [3:0]  r_d_icode;
    logic [3:0]  r_d_ifun;
    logic [3:0]  r_d_ra;
    logic [3:0]  r_d_rb;
    logic [63:0] r_d_valc;
    logic [63:0] r_d_valp;

    logic        w_mispredict;
    logic        w_ret;
    logic        w_redirect;
    logic [63:0] w_f_pc;
    logic [7:0]  w_byte [10];
    logic [3:0]  w_raw_icode;
    logic [3:0]  w_len;
    logic [64:0] w_end;
    logic        w_adr;
    logic [2:0]  w_stat;
    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [63:0] w_valc;
    logic [63:0] w_valp;
    logic [63:0] w_pred;
    logic        w_drain;
    logic        w_load;

    // Fetch PC select; a mispredicted jump outranks a returning ret
    always_comb begin
        w_mispredict = (M_icode == I_JXX) && !M_Cnd;
        w_ret        = (W_icode == I_RET);
        w_redirect   = w_mispredict || w_ret;
        if (w_mispredict) begin
            w_f_pc = M_valA;
        end else if (w_ret) begin
            w_f_pc = W_valM;
        end else begin
            w_f_pc = r_pred_pc;
        end
    end

    // Read up to ten bytes at f_pc; out-of-range bytes read as 0
    always_comb begin
        logic [63:0] v_addr;
        v_addr = '0;
        for (int k = 0; k < 10; k++) begin
            v_addr    = w_f_pc + 64'(k);
            w_byte[k] = 8'h00;
            if (v_addr < 64'(IMEM_SIZE)) begin
                w_byte[k] = r_imem[v_addr[AW-1:0]];
            end
        end
    end

    // Decode length, fields, status and next-PC prediction
    always_comb begin
        w_raw_icode = w_byte[0][7:4];
        unique case (w_raw_icode)
            4'd2, 4'd6, 4'd10, 4'd11: w_len = 4'd2;
            4'd3, 4'd4, 4'd5:         w_len = 4'd10;
            4'd7, 4'd8:               w_len = 4'd9;
            default:                  w_len = 4'd1;
        endcase
        // 65-bit so that an instruction wrapping past 2^64 is an address error
        w_end  = {1'b0, w_f_pc} + 65'(w_len) - 65'd1;
        w_adr  = (w_end >= 65'(IMEM_SIZE));
        w_icode = w_raw_icode;
        w_ifun  = w_byte[0][3:0];
        w_ra    = RNONE;
        w_rb    = RNONE;
        w_valc  = '0;
        w_stat  = SAOK;
        if (w_adr) begin
            w_icode = I_NOP;
            w_ifun  = 4'd0;
            w_stat  = SADR;
        end else begin
            unique case (w_raw_icode)
                4'd2, 4'd6, 4'd10, 4'd11: begin
                    w_ra = w_byte[1][7:4];
                    w_rb = w_byte[1][3:0];
                end
                4'd3, 4'd4, 4'd5: begin
                    w_ra   = w_byte[1][7:4];
                    w_rb   = w_byte[1][3:0];
                    w_valc = {w_byte[9], w_byte[8], w_byte[7], w_byte[6],
                              w_byte[5], w_byte[4], w_byte[3], w_byte[2]};
                end
                4'd7, 4'd8: begin
                    w_valc = {w_byte[8], w_byte[7], w_byte[6], w_byte[5],
                              w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
                end
                default: ;
            endcase
            if (w_raw_icode > 4'd11) begin
                w_stat = SINS;
            end else if (w_raw_icode == I_HALT) begin
                w_stat = SHLT;
            end
        end
        w_valp = w_f_pc + 64'(w_len);
        w_pred = ((w_icode == I_JXX) || (w_icode == I_CALL)) ? w_valc : w_valp;
    end

    // Drain holds fetch until a redirect arrives; w_load marks a parsed load into D
    always_comb begin
        w_drain = (r_state == ST_DRAIN) && !w_redirect;
        w_load  = !D_stall && !D_bubble && !w_drain;
    end

    // Instruction memory write port; not cleared by reset
    always_ff @(posedge clk) begin
        if (imem_we && (imem_addr < 64'(IMEM_SIZE))) begin
            r_imem[imem_addr[AW-1:0]] <= imem_wdata;
        end
    end

    // F_predPC and FETCH/DRAIN state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pred_pc <= RESET_PC;
            r_state   <= ST_FETCH;
        end else begin
            if (!F_stall && !w_drain) begin
                r_pred_pc <= w_pred;
            end
            if (w_load && (w_stat != SAOK)) begin
                r_state <= ST_DRAIN;
            end else if ((r_state == ST_DRAIN) && w_redirect) begin
                r_state <= ST_FETCH;
            end
        end
    end

    // D pipeline register: reset, stall, bubble, then normal load
    always_ff @(posedge clk) begin
        if (!rst_n || (!D_stall && !w_load)) begin
            r_d_stat  <= SAOK;
            r_d_icode <= I_NOP;
            r_d_ifun  <= 4'd0;
            r_d_ra    <= RNONE;
            r_d_rb    <= RNONE;
            r_d_valc  <= '0;
            r_d_valp  <= '0;
        end else if (w_load) begin
            r_d_stat  <= w_stat;
            r_d_icode <= w_icode;
            r_d_ifun  <= w_ifun;
            r_d_ra    <= w_ra;
            r_d_rb    <= w_rb;
            r_d_valc  <= w_valc;
            r_d_valp  <= w_valp;
        end
    end

    assign D_stat  = r_d_stat;
    assign D_icode = r_d_icode;
    assign D_ifun  = r_d_ifun;
    assign D_rA    = r_d_ra;
    assign D_rB    = r_d_rb;
    assign D_valC  = r_d_valc;
    assign D_valP  = r_d_valp;

`ifdef FETCH_CNT_EN
    logic [31:0] r_fetch_count;

    // Count parsed (non-bubble) instructions entering D
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_dreg.sv
// Directed bench for fetch_dreg: one task per scenario, inline comparisons.
module tb_fetch_dreg;

`ifdef FETCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [7:0]  imem_wdata;
    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;
    logic [31:0] fetch_count;

    int checks;
    int errors;

    fetch_dreg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .F_stall     (F_stall),
        .D_stall     (D_stall),
        .D_bubble    (D_bubble),
        .M_icode     (M_icode),
        .M_Cnd       (M_Cnd),
        .M_valA      (M_valA),
        .W_icode     (W_icode),
        .W_valM      (W_valM),
        .D_stat      (D_stat),
        .D_icode     (D_icode),
        .D_ifun      (D_ifun),
        .D_rA        (D_rA),
        .D_rB        (D_rB),
        .D_valC      (D_valC),
        .D_valP      (D_valP),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        M_icode  = 4'd0;
        M_Cnd    = 1'b0;
        M_valA   = 64'd0;
        W_icode  = 4'd0;
        W_valM   = 64'd0;
    endtask

    task automatic wr(input logic [63:0] a, input logic [7:0] d);
        imem_we    = 1'b1;
        imem_addr  = a;
        imem_wdata = d;
        step();
        imem_we    = 1'b0;
    endtask

    task automatic wr_q(input logic [63:0] a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) wr(a + 64'(i), v[8*i +: 8]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_ctl();
        step();
        step();
        checks++;
        if ({D_stat, D_icode, D_ifun, D_rA, D_rB} !== {3'd1, 4'd1, 4'd0, 4'hF, 4'hF}) begin
            errors++;
            $display("FAIL reset_fields got %h want %h", {D_stat, D_icode, D_ifun, D_rA, D_rB},
                     {3'd1, 4'd1, 4'd0, 4'hF, 4'hF});
        end
        checks++;
        if ({D_valC, D_valP, fetch_count} !== 160'd0) begin
            errors++;
            $display("FAIL reset_vals got valC %h valP %h cnt %0d want 0 0 0",
                     D_valC, D_valP, fetch_count);
        end
    endtask

    task automatic test_irmovq();
        rst_n = 1'b0;
        wr(0, 8'h30);
        wr(1, 8'hF0);
        wr_q(2, 64'h10);
        wr(10, 8'h10);
        wr(11, 8'h10);
        rst_n = 1'b1;
        step();
        checks++;
        if ({D_stat, D_icode, D_ifun, D_rA, D_rB} !== {3'd1, 4'd3, 4'd0, 4'hF, 4'd0}) begin
            errors++;
            $display("FAIL irmovq_fields got %h want %h", {D_stat, D_icode, D_ifun, D_rA, D_rB},
                     {3'd1, 4'd3, 4'd0, 4'hF, 4'd0});
        end
        checks++;
        if ({D_valC, D_valP} !== {64'h10, 64'd10}) begin
            errors++;
            $display("FAIL irmovq_valc_valp got %h %h want 10 a", D_valC, D_valP);
        end
        step();
        checks++;
        if ({D_icode, D_valP} !== {4'd1, 64'd11}) begin
            errors++;
            $display("FAIL predpc_seq got icode %0d valP %0d want 1 11", D_icode, D_valP);
        end
        step();
        checks++;
        if (fetch_count !== (CNT_ON ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL count_three got %0d want %0d", fetch_count, CNT_ON ? 3 : 0);
        end
    endtask

    task automatic test_mispredict();
        rst_n = 1'b0;
        wr(0, 8'h74);
        wr_q(1, 64'h20);
        wr(9, 8'h10);
        wr(64'h20, 8'h00);
        rst_n = 1'b1;
        step();
        checks++;
        if ({D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} !==
            {4'd7, 4'd4, 4'hF, 4'hF, 64'h20, 64'd9}) begin
            errors++;
            $display("FAIL jne_parse got %0d %0d %h %h %h %h want 7 4 f f 20 9",
                     D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP);
        end
        M_icode = 4'd7;
        M_Cnd   = 1'b0;
        M_valA  = 64'd9;
        step();
        checks++;
        if ({D_stat, D_icode, D_valP} !== {3'd1, 4'd1, 64'd10}) begin
            errors++;
            $display("FAIL mispredict_redirect got stat %0d icode %0d valP %0d want 1 1 10",
                     D_stat, D_icode, D_valP);
        end
        clear_ctl();
    endtask

    task automatic test_ret_priority();
        rst_n = 1'b0;
        wr(0, 8'h10);
        wr(64'h30, 8'h10);
        wr(64'h40, 8'h20);
        wr(64'h41, 8'h12);
        wr(64'h42, 8'h10);
        W_icode = 4'd9;
        W_valM  = 64'h40;
        M_icode = 4'd7;
        M_Cnd   = 1'b0;
        M_valA  = 64'h30;
        rst_n   = 1'b1;
        step();
        checks++;
        if ({D_icode, D_valP} !== {4'd1, 64'h31}) begin
            errors++;
            $display("FAIL mispredict_over_ret got icode %0d valP %h want 1 31", D_icode, D_valP);
        end
        M_icode = 4'd0;
        step();
        checks++;
        if ({D_icode, D_rA, D_rB, D_valP} !== {4'd2, 4'd1, 4'd2, 64'h42}) begin
            errors++;
            $display("FAIL ret_redirect got %0d %0d %0d %h want 2 1 2 42",
                     D_icode, D_rA, D_rB, D_valP);
        end
        W_icode = 4'd0;
        M_icode = 4'd7;
        M_Cnd   = 1'b1;
        M_valA  = 64'h30;
        step();
        checks++;
        if ({D_icode, D_valP} !== {4'd1, 64'h43}) begin
            errors++;
            $display("FAIL taken_no_redirect got icode %0d valP %h want 1 43", D_icode, D_valP);
        end
        clear_ctl();
    endtask

    task automatic test_ins_drain();
        rst_n = 1'b0;
        wr(0, 8'hC0);
        wr(5, 8'h10);
        wr(6, 8'h10);
        rst_n = 1'b1;
        step();
        checks++;
        if ({D_stat, D_icode} !== {3'd3, 4'hC}) begin
            errors++;
            $display("FAIL ins_stat got stat %0d icode %0d want 3 12", D_stat, D_icode);
        end
        step();
        step();
        checks++;
        if ({D_stat, D_icode, D_valP, fetch_count} !==
            {3'd1, 4'd1, 64'd0, (CNT_ON ? 32'd1 : 32'd0)}) begin
            errors++;
            $display("FAIL drain_bubble got stat %0d icode %0d valP %0d cnt %0d want 1 1 0 %0d",
                     D_stat, D_icode, D_valP, fetch_count, CNT_ON ? 1 : 0);
        end
        M_icode = 4'd7;
        M_Cnd   = 1'b0;
        M_valA  = 64'd5;
        step();
        checks++;
        if ({D_stat, D_icode, D_valP} !== {3'd1, 4'd1, 64'd6}) begin
            errors++;
            $display("FAIL drain_resume got stat %0d icode %0d valP %0d want 1 1 6",
                     D_stat, D_icode, D_valP);
        end
        clear_ctl();
        step();
        checks++;
        if ({D_valP, fetch_count} !== {64'd7, (CNT_ON ? 32'd3 : 32'd0)}) begin
            errors++;
            $display("FAIL fetch_after_resume got valP %0d cnt %0d want 7 %0d",
                     D_valP, fetch_count, CNT_ON ? 3 : 0);
        end
    endtask

    task automatic test_adr_halt();
        rst_n = 1'b0;
        wr(0, 8'h70);
        wr_q(1, 64'd1023);
        wr(1023, 8'h10);
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({D_stat, D_icode, D_valP} !== {3'd1, 4'd1, 64'd1024}) begin
            errors++;
            $display("FAIL last_byte_ok got stat %0d icode %0d valP %0d want 1 1 1024",
                     D_stat, D_icode, D_valP);
        end
        step();
        checks++;
        if ({D_stat, D_icode, D_ifun} !== {3'd2, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL past_end_adr got stat %0d icode %0d ifun %0d want 2 1 0",
                     D_stat, D_icode, D_ifun);
        end
        rst_n = 1'b0;
        wr_q(1, 64'd1019);
        wr(1019, 8'h30);
        wr(1020, 8'hF0);
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({D_stat, D_icode} !== {3'd2, 4'd1}) begin
            errors++;
            $display("FAIL irmovq_adr got stat %0d icode %0d want 2 1", D_stat, D_icode);
        end
        rst_n = 1'b0;
        wr(0, 8'h00);
        rst_n = 1'b1;
        step();
        checks++;
        if ({D_stat, D_icode, D_valP} !== {3'd4, 4'd0, 64'd1}) begin
            errors++;
            $display("FAIL halt_stat got stat %0d icode %0d valP %0d want 4 0 1",
                     D_stat, D_icode, D_valP);
        end
    endtask

    task automatic test_stall_bubble();
        rst_n = 1'b0;
        wr(0, 8'h30);
        wr(1, 8'hF0);
        wr_q(2, 64'h10);
        wr(10, 8'h20);
        wr(11, 8'h12);
        wr(12, 8'h10);
        rst_n = 1'b1;
        step();
        D_stall = 1'b1;
        F_stall = 1'b1;
        step();
        step();
        checks++;
        if ({D_icode, D_rB, D_valC, D_valP} !== {4'd3, 4'd0, 64'h10, 64'd10}) begin
            errors++;
            $display("FAIL stall_hold got icode %0d rB %0d valC %h valP %0d want 3 0 10 10",
                     D_icode, D_rB, D_valC, D_valP);
        end
        D_stall = 1'b0;
        F_stall = 1'b0;
        step();
        checks++;
        if ({D_icode, D_valP} !== {4'd2, 64'd12}) begin
            errors++;
            $display("FAIL after_stall got icode %0d valP %0d want 2 12", D_icode, D_valP);
        end
        D_bubble = 1'b1;
        step();
        checks++;
        if ({D_stat, D_icode, D_rA, D_rB, D_valC, D_valP} !==
            {3'd1, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0}) begin
            errors++;
            $display("FAIL bubble got stat %0d icode %0d rA %h rB %h valC %h valP %h",
                     D_stat, D_icode, D_rA, D_rB, D_valC, D_valP);
        end
        D_bubble = 1'b0;
        rst_n    = 1'b0;
        step();
        checks++;
        if ({D_icode, D_valP, fetch_count} !== {4'd1, 64'd0, 32'd0}) begin
            errors++;
            $display("FAIL midstream_reset got icode %0d valP %0d cnt %0d want 1 0 0",
                     D_icode, D_valP, fetch_count);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({D_icode, D_valP, fetch_count} !== {4'd3, 64'd10, (CNT_ON ? 32'd1 : 32'd0)}) begin
            errors++;
            $display("FAIL restart_at_reset_pc got icode %0d valP %0d cnt %0d want 3 10 %0d",
                     D_icode, D_valP, fetch_count, CNT_ON ? 1 : 0);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = 64'd0;
        imem_wdata = 8'd0;
        clear_ctl();
        test_reset();
        test_irmovq();
        test_mispredict();
        test_ret_priority();
        test_ins_drain();
        test_adr_halt();
        test_stall_bubble();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_dreg.md
Name: fetch_dreg

Overview:
Fetch stage of the Y86-64 pipeline, combined with the D pipeline register that feeds decode_writeBack.
- Holds an internal byte-addressed instruction memory and the F_predPC register.
- Selects the fetch PC from the prediction, a mispredicted-branch redirect or a ret redirect.
- Parses one instruction per cycle and registers D_stat/D_icode/D_ifun/D_rA/D_rB/D_valC/D_valP under stall/bubble control.

Parameters:
IMEM_SIZE, 1024, instruction memory size in bytes
RESET_PC, 0, F_predPC value after reset

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
imem_we  input  1  instruction-memory byte write enable (bench/loader)
imem_addr  input  64  byte write address; writes at or above IMEM_SIZE are ignored
imem_wdata  input  8  byte write data
F_stall  input  1  hold F_predPC
D_stall  input  1  hold D register
D_bubble  input  1  load nop bubble into D register
M_icode  input  4  memory-stage icode
M_Cnd  input  1  memory-stage condition result
M_valA  input  64  fall-through PC of jump in M
W_icode  input  4  write-back-stage icode
W_valM  input  64  return address popped by ret in W
D_stat  output  3  registered status (1 AOK, 2 ADR, 3 INS, 4 HLT)
D_icode  output  4  registered icode
D_ifun  output  4  registered ifun
D_rA  output  4  registered rA (15 = none)
D_rB  output  4  registered rB (15 = none)
D_valC  output  64  registered constant
D_valP  output  64  registered next-sequential PC
fetch_count  output  32  instructions loaded into D (see Optional Feature)

Behaviour:
- PC select (combinational):
  - If M_icode==7 and !M_Cnd: f_pc = M_valA.
  - Else if W_icode==9: f_pc = W_valM.
  - Else: f_pc = F_predPC.
  - Mispredict has priority over ret.
- Instruction parse at f_pc, little-endian:
  - byte0 gives icode = bits 7:4, ifun = bits 3:0.
  - Instruction length by icode:
    - 0, 1, 9: 1 byte.
    - 2, 6, 10, 11: 2 bytes; byte1 gives rA = bits 7:4, rB = bits 3:0.
    - 3, 4, 5: 10 bytes; byte1 gives rA/rB, valC = bytes 2-9.
    - 7, 8: 9 bytes; valC = bytes 1-8, rA = rB = 15.
  - Fields not present in an instruction are 15 (registers) or 0 (valC).
  - valP = f_pc + length, 64-bit wrap.
- Status:
  - SADR if f_pc + length - 1 >= IMEM_SIZE, evaluated in 65-bit arithmetic so wrap counts as an error.
  - Else SINS if icode > 11.
  - Else SHLT if icode == 0.
  - Else SAOK.
  - On SADR, icode/ifun are forced to 1/0 and all bytes read as 0.
- Prediction: f_predPC = valC for icode 7 or 8, else valP.
- FSM, states FETCH and DRAIN:
  - FETCH: each posedge without F_stall, F_predPC <= f_predPC.
  - FETCH -> DRAIN when the instruction loaded into D (not stalled, not bubbled) has stat != SAOK.
  - DRAIN: F_predPC holds; D loads bubbles regardless of parse result, unless D_stall is asserted.
  - DRAIN -> FETCH on a mispredict or ret redirect. In that cycle the instruction at the redirect target is loaded normally.
- D register update on posedge, in priority order:
  1. rst_n == 0.
  2. D_stall: hold all fields.
  3. D_bubble or DRAIN: load bubble.
  4. Otherwise: load the parsed fields.
- Bubble contents: stat 1, icode 1, ifun 0, rA = rB = 15, valC = 0, valP = 0.
- Reset (synchronous, also mid-operation): F_predPC = RESET_PC, state = FETCH, D = bubble, fetch_count = 0. Instruction memory contents are not cleared.
- Instruction memory:
  - Write is synchronous on posedge when imem_we is high.
  - A fetch in the same cycle as a write sees the old byte.
  - Write is permitted during reset.

Optional Feature:
FETCH_CNT_EN
- Defined: fetch_count increments by 1 (wrapping at 2^32) on each posedge where D is loaded with a parsed, non-bubble instruction. Cleared by reset.
- Undefined: the counter logic is absent and fetch_count is tied to 0.

Test Plan:
- Load 30 F0 10 00 00 00 00 00 00 00 at 0, release reset -> D_icode 3, ifun 0, rA 15, rB 0, valC 0x10, valP 10, stat 1; next F_predPC 10.
- jne at 0 (74, target 0x20), next cycle drive M_icode 7, M_Cnd 0, M_valA 9 -> that cycle fetches from PC 9, not from 0x20.
- W_icode 9 with W_valM 0x40 plus a concurrent mispredict with M_valA 0x30 -> fetch from 0x30. Without the mispredict -> fetch from 0x40.
- Byte 0xC0 at PC 0 -> D_stat 3, FSM enters DRAIN, following cycles give D_icode 1 with F_predPC frozen. Asserting the mispredict redirect resumes fetch.
- irmovq placed at IMEM_SIZE-5 -> D_stat 2, D_icode 1. Halt (00) -> D_stat 4.
- Assert D_stall for 2 cycles -> D unchanged. D_bubble -> D_icode 1. rst_n low mid-stream -> next posedge D is the bubble and F_predPC = RESET_PC; fetch_count is 0 with FETCH_CNT_EN and counts 3 after 3 loads.
